// File: rtl/mips_pkg.sv
// mips_pkg: shared datapath widths, register-file constants and the word type.
`default_nettype none

package mips_pkg;

  localparam int WIDTH    = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_ZERO = 0;

  typedef logic [WIDTH-1:0] word_t;

endpackage : mips_pkg

`default_nettype wire

// File: rtl/hilo_reg.sv
// hilo_reg: HI/LO multiply/divide result pair, written together under one enable.
`default_nettype none

module hilo_reg
  import mips_pkg::*;
#(
  parameter int WIDTH = mips_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] hi_wd,
  input  logic [WIDTH-1:0] lo_wd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (we) begin
      hi_d = hi_wd;
      lo_d = lo_wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule : hilo_reg

`default_nettype wire

// File: rtl/mips_regfile.sv
// mips_regfile: 32-entry GPR file with two combinational read ports, one write
// port with optional same-cycle write-through, $0 hard-wired to zero, plus HI/LO.
`default_nettype none

module mips_regfile
  import mips_pkg::*;
#(
  parameter int WIDTH  = mips_pkg::WIDTH,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic              hilo_we,
  input  logic [WIDTH-1:0]  hi_wd,
  input  logic [WIDTH-1:0]  lo_wd,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);

  localparam int                NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  logic [WIDTH-1:0] regs [NREG];

  // $0 has no storage; every other entry is its own async-reset register.
  assign regs[0] = '0;

  generate
    for (genvar i = 1; i < NREG; i++) begin : g_gpr
      logic [WIDTH-1:0] gpr_q, gpr_d;

      always_comb begin
        gpr_d = gpr_q;
        if (we && (wa == ADDR_W'(i))) gpr_d = wd;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) gpr_q <= '0;
        else        gpr_q <= gpr_d;
      end

      assign regs[i] = gpr_q;
    end
  endgenerate

  // Write-through is gated by rst_n so reads stay 0 throughout reset.
  logic byp_en;
  assign byp_en = BYPASS && we && rst_n;

  always_comb begin
    rd1 = regs[ra1];
    rd2 = regs[ra2];
    if (byp_en && (wa == ra1)) rd1 = wd;
    if (byp_en && (wa == ra2)) rd2 = wd;
    if (ra1 == ZERO) rd1 = '0;
    if (ra2 == ZERO) rd2 = '0;
  end

  hilo_reg #(
    .WIDTH (WIDTH)
  ) u_hilo (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (hilo_we),
    .hi_wd (hi_wd),
    .lo_wd (lo_wd),
    .hi    (hi),
    .lo    (lo)
  );

endmodule : mips_regfile

`default_nettype wire

// File: tb/tb_mips_regfile.sv
// tb_mips_regfile: directed checks of a bypassing and a non-bypassing register file.
`default_nettype none
`timescale 1ns/1ps

module tb_mips_regfile;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa;
  logic        we, hilo_we;
  word_t       wd, hi_wd, lo_wd;
  word_t       rd1_b, rd2_b, hi_b, lo_b;
  word_t       rd1_n, rd2_n, hi_n, lo_n;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mips_regfile #(.BYPASS(1'b1)) u_byp (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .we(we), .wa(wa), .wd(wd), .hilo_we(hilo_we), .hi_wd(hi_wd), .lo_wd(lo_wd),
    .hi(hi_b), .lo(lo_b)
  );

  mips_regfile #(.BYPASS(1'b0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
    .we(we), .wa(wa), .wd(wd), .hilo_we(hilo_we), .hi_wd(hi_wd), .lo_wd(lo_wd),
    .hi(hi_n), .lo(lo_n)
  );

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; hilo_we = 1'b0;
    ra1 = '0; ra2 = '0; wa = '0; wd = '0; hi_wd = '0; lo_wd = '0;
    #2;
    chk("reset_rd1", rd1_b, 32'h0);
    chk("reset_hi",  hi_b,  32'h0);
    edge_step();
    rst_n = 1'b1;

    // Load r5 and HI/LO, then assert reset between edges.
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    hilo_we = 1'b1; hi_wd = 32'hAAAA_0001; lo_wd = 32'h5555_0002;
    edge_step();
    we = 1'b0; hilo_we = 1'b0; ra1 = 5'd5;
    #1;
    chk("pre_reset_r5", rd1_b, 32'hDEADBEEF);
    chk("pre_reset_hi", hi_b,  32'hAAAA_0001);
    rst_n = 1'b0;
    #1;
    chk("async_reset_r5_byp",   rd1_b, 32'h0);
    chk("async_reset_r5_nobyp", rd1_n, 32'h0);
    chk("async_reset_hi",       hi_b,  32'h0);
    chk("async_reset_lo",       lo_b,  32'h0);
    edge_step();
    rst_n = 1'b1;

    // Basic write/read on consecutive edges.
    we = 1'b1; wa = 5'd8; wd = 32'd100;
    edge_step();
    wa = 5'd9; wd = -32'sd100;
    edge_step();
    we = 1'b0; ra1 = 5'd8; ra2 = 5'd9;
    #1;
    chk("r8_read", rd1_b, 32'h00000064);
    chk("r9_read", rd2_b, 32'hFFFFFF9C);
    chk("r9_read_nobyp", rd2_n, 32'hFFFFFF9C);

    // $0 protection.
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0; ra2 = 5'd0;
    #1;
    chk("r0_wcycle_rd1", rd1_b, 32'h0);
    chk("r0_wcycle_rd2", rd2_b, 32'h0);
    edge_step();
    we = 1'b0;
    #1;
    chk("r0_after_rd1", rd1_b, 32'h0);
    chk("r0_after_rd2_nobyp", rd2_n, 32'h0);

    // Bypass vs. no bypass with r3 = 7.
    we = 1'b1; wa = 5'd3; wd = 32'd7;
    edge_step();
    wd = 32'd42; ra1 = 5'd3; ra2 = 5'd3;
    #1;
    chk("byp_pre_rd1",   rd1_b, 32'd42);
    chk("byp_pre_rd2",   rd2_b, 32'd42);
    chk("nobyp_pre_rd1", rd1_n, 32'd7);
    chk("nobyp_pre_rd2", rd2_n, 32'd7);
    edge_step();
    we = 1'b0;
    #1;
    chk("byp_post_rd1",   rd1_b, 32'd42);
    chk("nobyp_post_rd2", rd2_n, 32'd42);

    // HI/LO and GPR write on the same edge.
    hilo_we = 1'b1; hi_wd = 32'h1; lo_wd = 32'h80000000;
    we = 1'b1; wa = 5'd31; wd = 32'h400;
    edge_step();
    hilo_we = 1'b0; we = 1'b0; ra1 = 5'd31;
    hi_wd = 32'hFFFF_FFFF; lo_wd = 32'h1234_5678;
    #1;
    chk("hilo_hi",  hi_b,  32'h1);
    chk("hilo_lo",  lo_b,  32'h80000000);
    chk("hilo_r31", rd1_b, 32'h400);
    chk("hilo_lo_nobyp", lo_n, 32'h80000000);
    edge_step();
    chk("hilo_hold_hi", hi_b, 32'h1);
    chk("hilo_hold_lo", lo_b, 32'h80000000);

    // Reset falls while a write is pending: the write is lost.
    we = 1'b1; wa = 5'd10; wd = 32'h123; ra1 = 5'd10;
    #1;
    rst_n = 1'b0;
    edge_step();
    rst_n = 1'b1; we = 1'b0;
    #1;
    chk("reset_pending_r10", rd1_b, 32'h0);
    chk("reset_pending_r10_nobyp", rd1_n, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mips_regfile

`default_nettype wire

// File: doc/mips_regfile.md
# mips_regfile

Architectural register file for the MIPS datapath: 32 × 32-bit general-purpose registers with two combinational read ports and one synchronous write port, plus the HI/LO pair. It sits at the consuming end of the write-back selection path: the 32-bit write-back mux output (ALU result vs. memory data) drives `wd`. The block stores that value, holds `$0` at zero, and forwards same-cycle writes to the readers.

## Interface
- `WIDTH`, 32, data width of every register.
- `ADDR_W`, 5, register address width; register count is 2^ADDR_W.
- `BYPASS`, 1, 1 = same-cycle write-through to read ports; 0 = reads see written data only after the clock edge.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ra1`  in  ADDR_W  read address, port 1 (rs).
- `ra2`  in  ADDR_W  read address, port 2 (rt).
- `rd1`  out  WIDTH  read data, port 1.
- `rd2`  out  WIDTH  read data, port 2.
- `we`  in  1  GPR write enable.
- `wa`  in  ADDR_W  GPR write address.
- `wd`  in  WIDTH  GPR write data (from the write-back mux).
- `hilo_we`  in  1  HI/LO write enable.
- `hi_wd`  in  WIDTH  HI write data.
- `lo_wd`  in  WIDTH  LO write data.
- `hi`  out  WIDTH  HI register contents.
- `lo`  out  WIDTH  LO register contents.

## Operation
- **Reset (`rst_n` = 0):**
  - All GPRs, HI and LO clear to 0 immediately, without waiting for a clock edge.
  - `rd1`/`rd2` read 0 for every address; `hi`/`lo` are 0.
  - `we` and `hilo_we` are ignored while reset is asserted.
- **GPR write:** on a rising edge with `rst_n` = 1 and `we` = 1, `reg[wa]` ← `wd`.
  - A write to `wa` = 0 is discarded; `$0` is never stored.
- **Read:** `rdN` = `reg[raN]`, purely combinational.
  - `raN` = 0 always yields 0, including when bypass would otherwise apply.
- **Bypass (BYPASS = 1):** if `we` = 1, `wa` = `raN` and `raN` ≠ 0, then `rdN` = `wd` in the same cycle.
  - Both ports may bypass simultaneously.
- **HI/LO:** on a rising edge with `hilo_we` = 1, HI ← `hi_wd` and LO ← `lo_wd`, always together.
  - No partial HI/LO write exists.
  - `hi`/`lo` are register outputs with no bypass.
- **Simultaneous events:**
  - GPR write and HI/LO write in the same cycle are independent; both complete.
  - Reading and writing the same address in one cycle: new data with BYPASS = 1, old data with BYPASS = 0. New data is visible on the next cycle in both cases.
- **Reset mid-operation:** if `rst_n` falls in the same cycle as a pending write, the write is lost and the register ends at 0.
- **Arithmetic:** none; data is stored bit-exact, with no sign handling.

## Timing
- Read latency: 0 cycles (combinational from `raN` and register state).
- Write latency: 1 edge. Data is visible through storage after the edge, or immediately via bypass.
- HI/LO latency: `hi`/`lo` change after the enabling edge.
- Reset deassertion: the first write is accepted on the first rising edge with `rst_n` = 1. Synchronize `rst_n` externally.
- Critical path: `wa`/`ra` compare → bypass mux → `rdN`. This feeds the ALU operand muxes downstream.

## Structure
- Shared package `mips_pkg` holds:
  - `WIDTH` and `ADDR_W` constants;
  - the `REG_ZERO` (0) address constant;
  - the `word_t` typedef.
- Sub-module `hilo_reg`: the HI/LO pair with common enable and async reset.
- The GPR array, zero-gating and bypass logic stay in `mips_regfile`.

## Test plan
- **Reset clears:** write 0xDEADBEEF to r5, assert `rst_n` = 0 between edges.
  - `rd1` (`ra1` = 5) reads 0 immediately, without a clock edge.
  - `hi` and `lo` read 0.
- **Basic write/read:** write 100 to r8 and −100 to r9 on consecutive edges, then `ra1` = 8, `ra2` = 9.
  - `rd1` = 0x00000064, `rd2` = 0xFFFFFF9C.
- **$0 protection:** `we` = 1, `wa` = 0, `wd` = 0xFFFFFFFF, with `ra1` = `ra2` = 0.
  - Both ports read 0 in the write cycle (no bypass) and after the edge.
- **Bypass, BYPASS = 1:** r3 holds 7; in one cycle `we` = 1, `wa` = 3, `wd` = 42, `ra1` = `ra2` = 3.
  - Both ports read 42 before the edge and still 42 after it.
- **No bypass, BYPASS = 0:** repeat the bypass scenario.
  - Ports read 7 before the edge, then 42 after it.
- **HI/LO plus GPR together:** same edge with `hilo_we` = 1 (`hi_wd` = 0x1, `lo_wd` = 0x80000000) and `we` = 1 (`wa` = 31, `wd` = 0x400).
  - After the edge: `hi` = 0x1, `lo` = 0x80000000, r31 = 0x400.
  - A following edge with `hilo_we` = 0 leaves HI/LO unchanged.
